ex_stage_muldiv: RTL and testbench
==================================

Name: ex_stage_muldiv

Overview:
Next-generation execute stage for the 5-stage RISC-V pipeline. It is parametrised in XLEN and adds a valid/ready handshake on both sides, so it can stall upstream and back-pressure downstream. It adds multi-cycle RV-M multiply/divide through an internal iterative FSM. Forwarding, branch/jump resolution and the EX/MEM pipeline register are kept, and flush support is added.

Parameters:
XLEN, 32, datapath width in bits; legal values 32 and 64.
CTRL_W, 16, width of the opaque control bundle passed through to MEM.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
id_ex_valid  in  1  ID/EX holds an instruction
id_ex_ready  out  1  stage accepts the instruction this cycle
id_ex_pc  in  XLEN  instruction PC
id_ex_rs1_data, id_ex_rs2_data  in  XLEN  register operands
id_ex_immediate  in  XLEN  sign-extended immediate
id_ex_rd_addr  in  5  destination register
id_ex_op  in  5  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
id_ex_funct3  in  3  branch condition select
id_ex_alu_src  in  1  1 = operand B is the immediate
id_ex_branch, id_ex_jump, id_ex_jalr  in  1 each  control-flow flags
id_ex_control_signals  in  CTRL_W  passed through to MEM
forward_a, forward_b  in  2  forwarding select: 00 register file, 01 fwd_wb_data, 10 fwd_mem_data, 11 register file
fwd_mem_data, fwd_wb_data  in  XLEN  forwarded values
flush  in  1  kill the in-flight instruction and any accept this cycle
mem_ready  in  1  MEM consumes ex_mem_* this cycle
ex_mem_valid  out  1  EX/MEM register valid
ex_mem_pc, ex_mem_result, ex_mem_rs2_data  out  XLEN  EX/MEM payload
ex_mem_rd_addr  out  5  EX/MEM destination register
ex_mem_control_signals  out  CTRL_W  EX/MEM control
branch_taken  out  1  redirect fetch (combinational)
branch_target  out  XLEN  redirect address (combinational)
busy  out  1  multiply/divide FSM is active

Behaviour:
- Reset: every ex_mem_* output = 0, ex_mem_valid = 0, FSM = IDLE, busy = 0.
- Reset asserted mid-operation aborts the operation immediately.
- id_ex_ready = (state==IDLE) & (!ex_mem_valid | mem_ready) & !flush.
- Accept = id_ex_valid & id_ex_ready.
- Forwarded operands are resolved at accept; the M unit latches them, so later changes on the forwarding inputs are ignored.
- Operand B = alu_src ? immediate : forwarded rs2.
- Shift amount = B[log2(XLEN)-1:0].
- Undefined op codes produce result 0.
- ALU op, cycle T accept: ex_mem_* loaded at the T+1 edge.
  - Result = ALU output.
  - If jump: result = pc + 4.
- Branch: branch_taken = accept & ((branch & cond) | jump).
  - cond by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, others 0.
  - Comparisons use the forwarded operands.
- branch_target = jalr ? ((rs1 + imm) & ~1) : (pc + imm).
- branch_taken is never asserted while the stage is stalled.
- M op FSM, states IDLE -> BUSY -> IDLE:
  - On accept: latch operands, rd, pc, control and op; counter = XLEN; go to BUSY (busy=1).
  - Each BUSY cycle performs one radix-2 step: shift-add for multiply, restoring shift-subtract for divide. Counter decrements.
  - When counter reaches 1, at that edge: ex_mem_valid=1 with the final result, state -> IDLE.
  - Total latency: accept at T gives ex_mem_valid from T+XLEN+1.
- Signed operands are converted to magnitudes first; the result sign is fixed up in the final step.
  - MULH/MULHSU/MULHU return the upper XLEN bits of the 2·XLEN product; MUL returns the lower XLEN bits.
- Divide by zero: quotient all ones, remainder = dividend.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Both special cases keep the same fixed latency.
- While BUSY, id_ex_ready=0. ex_mem_valid drops when consumed by mem_ready; otherwise it holds.
- Output hold: when ex_mem_valid & !mem_ready, all ex_mem_* stay stable.
- Flush:
  - Clears ex_mem_valid and forces the FSM to IDLE (an M op in progress is discarded).
  - Blocks accept in the same cycle.
  - Flush has priority over completion in the same cycle.
- ex_mem_valid & mem_ready with no new result in the same cycle: ex_mem_valid -> 0 at the next edge.

Optional Feature:
EX_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use one combinational 2·XLEN product registered into the FSM. Latency is 2 cycles (ex_mem_valid from T+2), busy=1 for one cycle.
- Undefined: iterative multiply (XLEN+1 cycles).
- Divide is iterative in both builds.

Test Plan:
1. ADD, rs1=5, rs2=7, alu_src=0, mem_ready=1 -> ex_mem_result=12 one cycle after accept, ex_mem_valid=1, id_ex_ready stays 1.
2. BEQ, rs1=rs2=0x10, pc=0x100, imm=0x20; then with forward_a=10, fwd_mem_data=0x11 -> first case branch_taken=1, target=0x120; forwarded case branch_taken=0.
3. DIVU 100/7, XLEN=32 -> busy for 32 cycles, id_ex_ready=0 throughout, result 14 at T+33; REMU -> 2.
4. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5.
5. MULH -3 * 2 -> 0xFFFFFFFF; MUL gives 0xFFFFFFFA. Repeat with EX_FAST_MUL_EN defined -> same values, at T+2.
6. mem_ready=0 for 3 cycles with a result held -> ex_mem_* stable and id_ex_ready=0. Flush mid-DIV -> ex_mem_valid=0, busy=0, next ADD accepted next cycle.

Source files
------------

// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv - execute stage with valid/ready handshake and RV-M unit.
//
// Purpose: resolves forwarded operands, runs the single-cycle ALU, resolves
// branches/jumps combinationally and writes the EX/MEM pipeline register.
// Multiply/divide ops run in an iterative radix-2 unit (IDLE -> BUSY -> IDLE);
// the stage stalls upstream while the unit is busy.
//
// Build option: define EX_FAST_MUL_EN to compute multiplies with a single
// combinational product (2-cycle latency). Divide is always iterative.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   id_ex_*                 incoming instruction and its handshake
//   forward_a/b, fwd_*      operand forwarding selects and data
//   flush                   kill in-flight work and block accept
//   mem_ready               MEM consumes ex_mem_* this cycle
//   ex_mem_*                EX/MEM register outputs
//   branch_taken/target     combinational fetch redirect
//   busy                    multiply/divide unit active
module ex_stage_muldiv #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ex_valid,
    output logic              id_ex_ready,
    input  logic [XLEN-1:0]   id_ex_pc,
    input  logic [XLEN-1:0]   id_ex_rs1_data,
    input  logic [XLEN-1:0]   id_ex_rs2_data,
    input  logic [XLEN-1:0]   id_ex_immediate,
    input  logic [4:0]        id_ex_rd_addr,
    input  logic [4:0]        id_ex_op,
    input  logic [2:0]        id_ex_funct3,
    input  logic              id_ex_alu_src,
    input  logic              id_ex_branch,
    input  logic              id_ex_jump,
    input  logic              id_ex_jalr,
    input  logic [CTRL_W-1:0] id_ex_control_signals,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [XLEN-1:0]   fwd_mem_data,
    input  logic [XLEN-1:0]   fwd_wb_data,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              ex_mem_valid,
    output logic [XLEN-1:0]   ex_mem_pc,
    output logic [XLEN-1:0]   ex_mem_result,
    output logic [XLEN-1:0]   ex_mem_rs2_data,
    output logic [4:0]        ex_mem_rd_addr,
    output logic [CTRL_W-1:0] ex_mem_control_signals,
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_target,
    output logic              busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] mc_reg;      // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_reg;      // product high half or partial remainder
    logic [XLEN-1:0] lo_reg;      // multiplier/product low half or dividend/quotient
    logic [2:0]      mop_reg;     // low bits of the M op (bit 2 set = divide)
    logic            neg_reg;     // result must be negated in the final step
    logic            div_zero_reg;

    logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_result;
    logic            accept, is_mop, cond;

    always_comb begin
        op_a    = (forward_a == 2'b01) ? fwd_wb_data :
                  (forward_a == 2'b10) ? fwd_mem_data : id_ex_rs1_data;
        rs2_fwd = (forward_b == 2'b01) ? fwd_wb_data :
                  (forward_b == 2'b10) ? fwd_mem_data : id_ex_rs2_data;
        op_b    = id_ex_alu_src ? id_ex_immediate : rs2_fwd;
    end

    assign id_ex_ready = (state_reg == IDLE) && (!ex_mem_valid || mem_ready) && !flush;
    assign accept      = id_ex_valid && id_ex_ready;
    assign is_mop      = (id_ex_op[4:3] == 2'b10);
    assign busy        = (state_reg == BUSY);

    always_comb begin
        alu_result = '0;
        case (id_ex_op)
            5'd0: alu_result = op_a + op_b;
            5'd1: alu_result = op_a - op_b;
            5'd2: alu_result = op_a << op_b[SHW-1:0];
            5'd3: alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            5'd4: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            5'd5: alu_result = op_a ^ op_b;
            5'd6: alu_result = op_a >> op_b[SHW-1:0];
            5'd7: alu_result = $signed(op_a) >>> op_b[SHW-1:0];
            5'd8: alu_result = op_a | op_b;
            5'd9: alu_result = op_a & op_b;
            default: alu_result = '0;
        endcase
    end

    // Branch compare always uses rs2, never the immediate.
    always_comb begin
        cond = 1'b0;
        case (id_ex_funct3)
            3'b000: cond = (op_a == rs2_fwd);
            3'b001: cond = (op_a != rs2_fwd);
            3'b100: cond = ($signed(op_a) <  $signed(rs2_fwd));
            3'b101: cond = ($signed(op_a) >= $signed(rs2_fwd));
            3'b110: cond = (op_a <  rs2_fwd);
            3'b111: cond = (op_a >= rs2_fwd);
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken  = accept && ((id_ex_branch && cond) || id_ex_jump);
    assign branch_target = id_ex_jalr ? ((op_a + id_ex_immediate) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                      : (id_ex_pc + id_ex_immediate);

    // Operand magnitudes for the M unit. MUL's low half is sign-agnostic, so
    // treating it as signed is harmless.
    logic            sgn_a, sgn_b, neg_next;
    logic [XLEN-1:0] mag_a, mag_b;
    always_comb begin
        sgn_a    = op_a[XLEN-1] && (id_ex_op[2] ? !id_ex_op[0] : (id_ex_op[1:0] != 2'b11));
        sgn_b    = op_b[XLEN-1] && (id_ex_op[2] ? !id_ex_op[0] : !id_ex_op[1]);
        mag_a    = sgn_a ? -op_a : op_a;
        mag_b    = sgn_b ? -op_b : op_b;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_next = (id_ex_op[2:1] == 2'b11) ? sgn_a : (sgn_a ^ sgn_b);
    end

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    // One radix-2 step of the multiply (shift-add) and divide (restoring).
    logic [XLEN:0]     mul_sum, div_rsh;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo, div_sub;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot, rem, m_result;
    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mc_reg} : '0);
        div_rsh = {hi_reg, lo_reg[XLEN-1]};
        div_ge  = (div_rsh >= {1'b0, mc_reg});
        div_sub = div_rsh[XLEN-1:0] - mc_reg;  // fits: result < divisor when taken
        if (mop_reg[2]) begin
            step_hi = div_ge ? div_sub : div_rsh[XLEN-1:0];
            step_lo = {lo_reg[XLEN-2:0], div_ge};
        end else begin
`ifdef EX_FAST_MUL_EN
            step_hi = hi_reg;  // product already complete
            step_lo = lo_reg;
`else
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
`endif
        end
        prod   = {step_hi, step_lo};
        prod_s = neg_reg ? -prod : prod;
        quot   = div_zero_reg ? '1 : (neg_reg ? -step_lo : step_lo);
        rem    = neg_reg ? -step_hi : step_hi;
        case (mop_reg)
            3'd0:        m_result = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:        m_result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:  m_result = quot;
            default:     m_result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg              <= IDLE;
            count_reg              <= '0;
            mc_reg                 <= '0;
            hi_reg                 <= '0;
            lo_reg                 <= '0;
            mop_reg                <= '0;
            neg_reg                <= 1'b0;
            div_zero_reg           <= 1'b0;
            ex_mem_valid           <= 1'b0;
            ex_mem_pc              <= '0;
            ex_mem_result          <= '0;
            ex_mem_rs2_data        <= '0;
            ex_mem_rd_addr         <= '0;
            ex_mem_control_signals <= '0;
        end else if (flush) begin
            state_reg    <= IDLE;
            ex_mem_valid <= 1'b0;
        end else begin
            if (ex_mem_valid && mem_ready)
                ex_mem_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Payload is written at accept for both paths; for an M op
                        // ex_mem_valid is low until completion, so this is invisible.
                        ex_mem_pc              <= id_ex_pc;
                        ex_mem_rs2_data        <= rs2_fwd;
                        ex_mem_rd_addr         <= id_ex_rd_addr;
                        ex_mem_control_signals <= id_ex_control_signals;
                        if (is_mop) begin
                            state_reg    <= BUSY;
                            mop_reg      <= id_ex_op[2:0];
                            neg_reg      <= neg_next;
                            div_zero_reg <= (op_b == '0);
                            mc_reg       <= id_ex_op[2] ? mag_b : mag_a;
                            hi_reg       <= '0;
                            lo_reg       <= id_ex_op[2] ? mag_a : mag_b;
                            count_reg    <= CW'(XLEN);
`ifdef EX_FAST_MUL_EN
                            if (!id_ex_op[2]) begin
                                {hi_reg, lo_reg} <= fast_prod;
                                count_reg        <= CW'(1);
                            end
`endif
                        end else begin
                            ex_mem_valid  <= 1'b1;
                            ex_mem_result <= id_ex_jump ? (id_ex_pc + XLEN'(4)) : alu_result;
                        end
                    end
                end
                BUSY: begin
                    hi_reg    <= step_hi;
                    lo_reg    <= step_lo;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        ex_mem_valid  <= 1'b1;
                        ex_mem_result <= m_result;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
module tb_ex_stage_muldiv;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
`ifdef EX_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_ex_valid, id_ex_ready;
    logic [XLEN-1:0]   id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_immediate;
    logic [4:0]        id_ex_rd_addr, id_ex_op;
    logic [2:0]        id_ex_funct3;
    logic              id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_jalr;
    logic [CTRL_W-1:0] id_ex_control_signals;
    logic [1:0]        forward_a, forward_b;
    logic [XLEN-1:0]   fwd_mem_data, fwd_wb_data;
    logic              flush, mem_ready;
    logic              ex_mem_valid;
    logic [XLEN-1:0]   ex_mem_pc, ex_mem_result, ex_mem_rs2_data;
    logic [4:0]        ex_mem_rd_addr;
    logic [CTRL_W-1:0] ex_mem_control_signals;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
    logic              busy;

    ex_stage_muldiv #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset),
        .id_ex_valid(id_ex_valid), .id_ex_ready(id_ex_ready),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_immediate(id_ex_immediate), .id_ex_rd_addr(id_ex_rd_addr), .id_ex_op(id_ex_op),
        .id_ex_funct3(id_ex_funct3), .id_ex_alu_src(id_ex_alu_src), .id_ex_branch(id_ex_branch),
        .id_ex_jump(id_ex_jump), .id_ex_jalr(id_ex_jalr),
        .id_ex_control_signals(id_ex_control_signals),
        .forward_a(forward_a), .forward_b(forward_b),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .mem_ready(mem_ready),
        .ex_mem_valid(ex_mem_valid), .ex_mem_pc(ex_mem_pc), .ex_mem_result(ex_mem_result),
        .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_rd_addr(ex_mem_rd_addr),
        .ex_mem_control_signals(ex_mem_control_signals),
        .branch_taken(branch_taken), .branch_target(branch_target), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: RISC-V semantics with 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] p;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'(sa >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd16: begin p = 64'(sa * sb);   return p[31:0];  end
            5'd17: begin p = 64'(sa * sb);   return p[63:32]; end
            5'd18: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            5'd19: begin p = ua * ub;        return p[63:32]; end
            5'd20: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            5'd23: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
        case (s)
            2'b01:   return fwd_wb_data;
            2'b10:   return fwd_mem_data;
            default: return r;
        endcase
    endfunction

    // Issues the instruction currently on the id_ex_* inputs and checks it.
    task automatic run_op(input string tag);
        logic [31:0] a, b2, b, exp_res, exp_tgt;
        logic [CTRL_W-1:0] exp_ctrl;
        logic [31:0] exp_pc;
        logic [4:0]  exp_rd;
        logic        cnd, exp_taken;
        int          lat, n;
        @(negedge clk);
        a  = fwd(forward_a, id_ex_rs1_data);
        b2 = fwd(forward_b, id_ex_rs2_data);
        b  = id_ex_alu_src ? id_ex_immediate : b2;
        case (id_ex_funct3)
            3'b000:  cnd = (a == b2);
            3'b001:  cnd = (a != b2);
            3'b100:  cnd = ($signed(a) <  $signed(b2));
            3'b101:  cnd = ($signed(a) >= $signed(b2));
            3'b110:  cnd = (a <  b2);
            3'b111:  cnd = (a >= b2);
            default: cnd = 1'b0;
        endcase
        exp_taken = (id_ex_branch && cnd) || id_ex_jump;
        exp_tgt   = id_ex_jalr ? ((a + id_ex_immediate) & 32'hFFFF_FFFE) : (id_ex_pc + id_ex_immediate);
        exp_res   = id_ex_jump ? id_ex_pc + 32'd4 : model(id_ex_op, a, b);
        exp_pc    = id_ex_pc;
        exp_rd    = id_ex_rd_addr;
        exp_ctrl  = id_ex_control_signals;
        lat = (id_ex_op >= 5'd16 && id_ex_op <= 5'd19) ? MUL_LAT :
              (id_ex_op >= 5'd20 && id_ex_op <= 5'd23) ? DIV_LAT : 1;
        id_ex_valid = 1'b1;
        #1;
        check({tag, " ready"}, id_ex_ready, 1);
        check({tag, " taken"}, branch_taken, exp_taken);
        check({tag, " target"}, branch_target, exp_tgt);
        @(posedge clk);
        #1;
        id_ex_valid = 1'b0;
        // Operands must have been latched at accept.
        id_ex_rs1_data = $urandom; id_ex_rs2_data = $urandom;
        fwd_mem_data = $urandom;   fwd_wb_data = $urandom;
        n = 1;
        @(negedge clk);
        while (!ex_mem_valid && n < 64) begin
            check({tag, " busy"}, busy, 1);
            check({tag, " stall"}, id_ex_ready, 0);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, ex_mem_result, exp_res);
        check({tag, " pc"}, ex_mem_pc, exp_pc);
        check({tag, " rd"}, ex_mem_rd_addr, exp_rd);
        check({tag, " rs2"}, ex_mem_rs2_data, b2);
        check({tag, " ctrl"}, ex_mem_control_signals, exp_ctrl);
        $display("op %0d a=0x%08h b=0x%08h -> 0x%08h (lat %0d)", id_ex_op, a, b, ex_mem_result, n);
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        id_ex_op = op; id_ex_rs1_data = a; id_ex_rs2_data = b;
        id_ex_alu_src = 0; id_ex_branch = 0; id_ex_jump = 0; id_ex_jalr = 0;
        forward_a = 2'b00; forward_b = 2'b00; id_ex_funct3 = 3'b010;
        id_ex_pc = 32'h100; id_ex_immediate = 32'h20;
        id_ex_rd_addr = 5'd3; id_ex_control_signals = 16'hA5C3;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                                5'd12, 5'd27};
        logic [31:0] held;
        reset = 1; id_ex_valid = 0; flush = 0; mem_ready = 1;
        fwd_mem_data = 0; fwd_wb_data = 0;
        set_op(5'd0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset valid", ex_mem_valid, 0);
        check("reset result", ex_mem_result, 0);
        check("reset pc", ex_mem_pc, 0);
        check("reset rd", ex_mem_rd_addr, 0);
        check("reset ctrl", ex_mem_control_signals, 0);
        check("reset busy", busy, 0);
        reset = 0;

        set_op(5'd0, 5, 7);                       run_op("add");
        set_op(5'd0, 32'h10, 32'h10); id_ex_branch = 1; id_ex_funct3 = 3'b000; run_op("beq");
        set_op(5'd0, 32'h10, 32'h10); id_ex_branch = 1; id_ex_funct3 = 3'b000;
        forward_a = 2'b10; fwd_mem_data = 32'h11; run_op("beq fwd");
        set_op(5'd0, 32'h1001, 0); id_ex_jump = 1; id_ex_jalr = 1; id_ex_immediate = 32'h10;
        run_op("jalr");
        set_op(5'd21, 100, 7);                    run_op("divu");
        set_op(5'd23, 100, 7);                    run_op("remu");
        set_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF); run_op("div ovf");
        set_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF); run_op("rem ovf");
        set_op(5'd20, 5, 0);                      run_op("div zero");
        set_op(5'd22, 5, 0);                      run_op("rem zero");
        set_op(5'd20, 32'hFFFF_FFFB, 0);          run_op("div negzero");
        set_op(5'd17, 32'hFFFF_FFFD, 2);          run_op("mulh");
        set_op(5'd16, 32'hFFFF_FFFD, 2);          run_op("mul");

        // Back-pressure: result must hold and the stage must stall.
        set_op(5'd0, 3, 4);
        @(negedge clk); mem_ready = 0; id_ex_valid = 1;
        @(posedge clk); #1; id_ex_valid = 0;
        @(negedge clk);
        check("hold valid", ex_mem_valid, 1);
        held = ex_mem_result;
        check("hold result", held, 7);
        set_op(5'd1, 50, 8); id_ex_valid = 1;
        repeat (3) begin
            @(negedge clk);
            check("hold stable valid", ex_mem_valid, 1);
            check("hold stable result", ex_mem_result, 7);
            check("hold ready", id_ex_ready, 0);
        end
        id_ex_valid = 0; mem_ready = 1;
        @(negedge clk);
        check("drain valid", ex_mem_valid, 0);

        // Flush in the middle of a divide.
        set_op(5'd20, 1000, 3);
        @(negedge clk); id_ex_valid = 1;
        @(posedge clk); #1; id_ex_valid = 0;
        repeat (5) @(negedge clk);
        check("mid div busy", busy, 1);
        flush = 1; #1;
        check("flush ready", id_ex_ready, 0);
        @(posedge clk); #1; flush = 0;
        @(negedge clk);
        check("flush busy", busy, 0);
        check("flush valid", ex_mem_valid, 0);
        set_op(5'd0, 21, 21);                     run_op("add after flush");

        // Flush on the completion edge wins.
        set_op(5'd21, 77, 5);
        @(negedge clk); id_ex_valid = 1;
        @(posedge clk); #1; id_ex_valid = 0;
        repeat (XLEN) @(negedge clk);
        check("last step busy", busy, 1);
        flush = 1;
        @(posedge clk); #1; flush = 0;
        @(negedge clk);
        check("flush vs done valid", ex_mem_valid, 0);
        check("flush vs done busy", busy, 0);

        // Reset during an operation aborts it immediately.
        set_op(5'd21, 77, 5);
        @(negedge clk); id_ex_valid = 1;
        @(posedge clk); #1; id_ex_valid = 0;
        repeat (3) @(negedge clk);
        reset = 1; #1;
        check("async reset busy", busy, 0);
        check("async reset valid", ex_mem_valid, 0);
        @(negedge clk); reset = 0;

        // Randomized instructions against the model.
        for (int i = 0; i < 60; i++) begin
            set_op(ops[$urandom_range(0, 19)], rnd_operand(), rnd_operand());
            id_ex_immediate = rnd_operand();
            id_ex_alu_src = 1'($urandom_range(0, 1));
            forward_a = 2'($urandom_range(0, 3));
            forward_b = 2'($urandom_range(0, 3));
            fwd_mem_data = rnd_operand();
            fwd_wb_data  = rnd_operand();
            id_ex_pc = $urandom & 32'hFFFF_FFFC;
            id_ex_rd_addr = 5'($urandom);
            id_ex_control_signals = 16'($urandom);
            if (id_ex_op < 5'd16) begin
                id_ex_branch = ($urandom_range(0, 2) == 0);
                id_ex_funct3 = 3'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    id_ex_op = 5'd0; id_ex_branch = 0; id_ex_jump = 1;
                    id_ex_jalr = 1'($urandom_range(0, 1));
                end
            end
            run_op("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
